// File: rtl/seq_match_ctrl_if.sv
// -----------------------------------------------------------------------------
// seq_match_ctrl_if
// Bundles the configuration, control, byte-stream handshake and match-report
// signals of seq_match_ctrl.
//   master : drives cfg_we/cfg_pattern/cfg_len/cfg_overlap, start/stop,
//            in_valid/in_data; observes in_ready, match_pulse, match_count, busy.
//   slave  : the controller side (the mirror image).
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready
// are both high. in_data only has to be stable at that edge. in_ready never
// depends on in_valid, and a byte offered while in_ready is low simply waits.
// -----------------------------------------------------------------------------
interface seq_match_ctrl_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
);
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               start;
    logic               stop;
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               match_pulse;
    logic [CNT_W-1:0]   match_count;
    logic               busy;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, start, stop,
               in_valid, in_data,
        input  in_ready, match_pulse, match_count, busy
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, start, stop,
               in_valid, in_data,
        output in_ready, match_pulse, match_count, busy
    );
endinterface

// File: rtl/seq_match_ctrl.sv
// -----------------------------------------------------------------------------
// seq_match_ctrl
// Runtime-programmable serial pattern matcher. Bytes arrive over the bus
// handshake and are serialised MSB first into a MAX_LEN-bit history register.
// A match is flagged when the newest len bits equal the programmed pattern.
// Matches are reported as a one-cycle pulse and counted in a saturating
// counter.
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   bus         seq_match_ctrl_if.slave (config, control, byte stream, status)
//   dbg_state_o current FSM state (IDLE=0, ARMED=1, SHIFT=2)
// -----------------------------------------------------------------------------
module seq_match_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_match_ctrl_if.slave      bus,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t             state_q;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [LEN_W-1:0]   fill_q;
    logic [7:0]         byte_q;
    logic [2:0]         idx_q;
    logic               pulse_q;
    logic [CNT_W-1:0]   count_q;

    logic [MAX_LEN-1:0] hist_d;
    logic [LEN_W-1:0]   fill_d;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   len_clamped;
    logic               hit;
    logic               in_ready_w;
    logic               handshake;

    // Post-shift view of the matcher: the match decision looks at the history
    // and fill as they will be after this cycle's bit has been shifted in.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
        hist_d      = {hist_q[MAX_LEN-2:0], byte_q[idx_q]};
        fill_d      = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
        hit         = (len_q != '0) && (fill_d >= len_q) &&
                      ((hist_d & len_mask) == (pat_q & len_mask));
        len_clamped = (bus.cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.cfg_len;
    end

    // Ready in ARMED and on the last bit of a byte, so a held in_valid streams
    // one byte every 8 cycles without a gap.
    assign in_ready_w = (state_q == ARMED) || ((state_q == SHIFT) && (idx_q == 3'd0));
    assign handshake  = bus.in_valid && in_ready_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            byte_q  <= '0;
            idx_q   <= '0;
            pulse_q <= 1'b0;
            count_q <= '0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cfg_we) begin
                        pat_q <= bus.cfg_pattern;
                        len_q <= len_clamped;
                        ovl_q <= bus.cfg_overlap;
                    end
                    // stop has priority over a simultaneous start
                    if (bus.start && !bus.stop) begin
                        state_q <= ARMED;
                        hist_q  <= '0;
                        fill_q  <= '0;
                        count_q <= '0;
                    end
                end
                ARMED: begin
                    if (bus.stop) begin
                        state_q <= IDLE;
                        fill_q  <= '0;
                    end else if (handshake) begin
                        byte_q  <= bus.in_data;
                        idx_q   <= 3'd7;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.stop) begin
                        // the bit in flight is discarded, so no pulse for it
                        state_q <= IDLE;
                        fill_q  <= '0;
                    end else begin
                        hist_q <= hist_d;
                        idx_q  <= idx_q - 3'd1;
                        if (hit) begin
                            pulse_q <= 1'b1;
                            if (count_q != {CNT_W{1'b1}}) begin
                                count_q <= count_q + CNT_W'(1);
                            end
                            // non-overlap: matched bits may not be reused
                            fill_q <= ovl_q ? fill_d : '0;
                        end else begin
                            fill_q <= fill_d;
                        end
                        if (idx_q == 3'd0) begin
                            if (bus.in_valid) begin
                                byte_q <= bus.in_data;
                                idx_q  <= 3'd7;
                            end else begin
                                state_q <= ARMED;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_w;
    assign bus.match_pulse = pulse_q;
    assign bus.match_count = count_q;
    assign bus.busy        = (state_q != IDLE);
    assign dbg_state_o     = state_q;

endmodule
